// File: rtl/axi_wr_pkg.sv
// Shared types and AXI constants for the single-outstanding AXI3 write master.
package axi_wr_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'b001,
      SEND   = 3'b010,
      WAIT_B = 3'b100
   } state_e;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] AWLOCK_VAL  = 2'b00;
   localparam logic [3:0] AWCACHE_VAL = 4'b0000;
   localparam logic [2:0] AWPROT_VAL  = 3'b000;

   // Requests longer than the buffer are truncated to the buffer depth.
   function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/axi_wr_beat_ctr.sv
// Beat counter for the W channel: tracks the current beat, flags the last one
// and selects that beat's data out of the request buffer.
module axi_wr_beat_ctr #(
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 4
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          clr_i,
   input  logic                          adv_i,
   input  logic [7:0]                    len_i,
   input  logic [MAX_BEATS*DATA_W-1:0]   data_i,
   output logic                          last_o,
   output logic [DATA_W-1:0]             beat_o
);

   logic [7:0] cnt_q, cnt_d;

   assign last_o = (cnt_q == len_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (adv_i)
         cnt_d = last_o ? 8'd0 : cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   always_comb begin
      beat_o = '0;
      for (int i = 0; i < MAX_BEATS; i++)
         if (cnt_q == 8'(i))
            beat_o = data_i[i*DATA_W +: DATA_W];
   end

endmodule

// File: rtl/axi_wr_master.sv
// Single-outstanding AXI3 write master: buffers one burst, drives AW and W
// independently, then takes the B response. Optional AXI_WR_RESP_EN adds wr_err.
module axi_wr_master
   import axi_wr_pkg::*;
#(
   parameter int ID_W      = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 4,
   parameter int AXI_ID    = 1
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [ADDR_W-1:0]             req_addr,
   input  logic [2:0]                    req_size,
   input  logic [7:0]                    req_len,
   input  logic [DATA_W/8-1:0]           req_strb,
   input  logic [MAX_BEATS*DATA_W-1:0]   req_data,
   output logic                          wr_done,
`ifdef AXI_WR_RESP_EN
   output logic                          wr_err,
`endif
   output logic [ID_W-1:0]               awid,
   output logic [ADDR_W-1:0]             awaddr,
   output logic [7:0]                    awlen,
   output logic [2:0]                    awsize,
   output logic [1:0]                    awburst,
   output logic [1:0]                    awlock,
   output logic [3:0]                    awcache,
   output logic [2:0]                    awprot,
   output logic                          awvalid,
   input  logic                          awready,
   output logic [ID_W-1:0]               wid,
   output logic [DATA_W-1:0]             wdata,
   output logic [DATA_W/8-1:0]           wstrb,
   output logic                          wlast,
   output logic                          wvalid,
   input  logic                          wready,
   input  logic [ID_W-1:0]               bid,
   input  logic [1:0]                    bresp,
   input  logic                          bvalid,
   output logic                          bready
);

   localparam int         STRB_W  = DATA_W / 8;
   localparam logic [7:0] LEN_MAX = 8'(MAX_BEATS - 1);

   state_e                        state_q, state_d;
   logic                          aw_done_q, aw_done_d;
   logic                          w_done_q, w_done_d;
   logic [ADDR_W-1:0]             addr_q;
   logic [2:0]                    size_q;
   logic [7:0]                    len_q;
   logic [STRB_W-1:0]             strb_q;
   logic [MAX_BEATS*DATA_W-1:0]   data_q;
   logic                          accept;

   assign accept = req_valid && req_ready;

   always_comb begin
      state_d   = state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      req_ready = 1'b0;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      bready    = 1'b0;
      wr_done   = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = resetn;
            if (req_valid && resetn) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = SEND;
            end
         end
         SEND: begin
            awvalid = !aw_done_q;
            wvalid  = !w_done_q;
            if (awvalid && awready)
               aw_done_d = 1'b1;
            if (wvalid && wready && wlast)
               w_done_d = 1'b1;
            // Both channels may complete in the same cycle.
            if (aw_done_d && w_done_d)
               state_d = WAIT_B;
         end
         WAIT_B: begin
            bready = 1'b1;
            if (bvalid) begin
               wr_done = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         addr_q <= '0;
         size_q <= '0;
         len_q  <= '0;
         strb_q <= '0;
         data_q <= '0;
      end else if (accept) begin
         addr_q <= req_addr;
         size_q <= req_size;
         len_q  <= clamp_len(req_len, LEN_MAX);
         strb_q <= req_strb;
         data_q <= req_data;
      end
   end

   axi_wr_beat_ctr #(
      .DATA_W    (DATA_W),
      .MAX_BEATS (MAX_BEATS)
   ) u_beat_ctr (
      .clk    (clk),
      .resetn (resetn),
      .clr_i  (accept),
      .adv_i  (wvalid && wready),
      .len_i  (len_q),
      .data_i (data_q),
      .last_o (wlast),
      .beat_o (wdata)
   );

   assign awid    = ID_W'(AXI_ID);
   assign awaddr  = addr_q;
   assign awlen   = len_q;
   assign awsize  = size_q;
   assign awburst = BURST_INCR;
   assign awlock  = AWLOCK_VAL;
   assign awcache = AWCACHE_VAL;
   assign awprot  = AWPROT_VAL;
   assign wid     = ID_W'(AXI_ID);
   assign wstrb   = strb_q;

   // Only one write is ever outstanding, so bid carries no information.
`ifdef AXI_WR_RESP_EN
   logic wr_err_q;
   logic unused_b;
   assign unused_b = ^{bid, bresp[0]};

   always_ff @(posedge clk) begin
      if (!resetn)
         wr_err_q <= 1'b0;
      else if (accept)
         wr_err_q <= 1'b0;
      else if (bvalid && bready)
         wr_err_q <= bresp[1];
   end
   assign wr_err = wr_err_q;
`else
   logic unused_b;
   assign unused_b = ^{bid, bresp};
`endif

endmodule

// File: tb/tb_axi_wr_master.sv
// Self-checking bench for axi_wr_master: directed table plus random bursts,
// checked cycle by cycle against a transaction-level model of the write protocol.
module tb_axi_wr_master;

   localparam int ID_W      = 4;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int MAX_BEATS = 4;
   localparam int AXI_ID    = 1;
   localparam int STRB_W    = DATA_W / 8;
   localparam int BUF_W     = MAX_BEATS * DATA_W;

   logic                clk = 1'b0;
   logic                resetn;
   logic                req_valid, req_ready;
   logic [ADDR_W-1:0]   req_addr;
   logic [2:0]          req_size;
   logic [7:0]          req_len;
   logic [STRB_W-1:0]   req_strb;
   logic [BUF_W-1:0]    req_data;
   logic                wr_done;
   logic [ID_W-1:0]     awid, wid, bid;
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize, awprot;
   logic [1:0]          awburst, awlock, bresp;
   logic [3:0]          awcache;
   logic                awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [DATA_W-1:0]   wdata;
   logic [STRB_W-1:0]   wstrb;
`ifdef AXI_WR_RESP_EN
   logic                wr_err;
`endif

   always #5 clk = ~clk;

   axi_wr_master #(
      .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .AXI_ID(AXI_ID)
   ) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
      .req_len(req_len), .req_strb(req_strb), .req_data(req_data), .wr_done(wr_done),
`ifdef AXI_WR_RESP_EN
      .wr_err(wr_err),
`endif
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   int errs   = 0;
   int checks = 0;
   logic exp_err = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [STRB_W-1:0] strb;
      logic [BUF_W-1:0]  data;
      int                aw_hold;   // cycles awready is held low after accept
      int                wmode;     // 0: wready=1, 1: toggle, 2: random
      bit                b_early;   // bvalid raised from the accept cycle
      logic [1:0]        bresp;
      logic [7:0]        exp_awlen;
   } vec_t;

   function automatic vec_t mk(input logic [ADDR_W-1:0] a, input logic [7:0] l,
                               input logic [STRB_W-1:0] s, input logic [BUF_W-1:0] d,
                               input int awh, input int wm, input bit be,
                               input logic [1:0] br, input logic [7:0] el);
      vec_t v;
      v.addr = a; v.len = l; v.size = 3'd2; v.strb = s; v.data = d;
      v.aw_hold = awh; v.wmode = wm; v.b_early = be; v.bresp = br; v.exp_awlen = el;
      return v;
   endfunction

   task automatic idle_inputs();
      req_valid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      bresp = 2'b00; bid = 4'(AXI_ID);
   endtask

   // One full write, compared cycle by cycle against the protocol model:
   // AW once, beats in order, B only after both channels finish.
   task automatic run_txn(input vec_t v);
      int  aw_cnt, beat, nbeats;
      bit  bv, done, both;
      logic [DATA_W-1:0] exp_d;
      nbeats = int'(v.exp_awlen) + 1;
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = v.addr; req_size = v.size; req_len = v.len;
      req_strb = v.strb; req_data = v.data;
      awready = 1'b0; wready = 1'b0; bvalid = v.b_early; bresp = v.bresp;
      #1;
      chk("req_ready_idle", req_ready, 1);
      chk("awvalid_at_accept", awvalid, 0);
      chk("wvalid_at_accept", wvalid, 0);
`ifdef AXI_WR_RESP_EN
      chk("wr_err_before_accept", wr_err, exp_err);
`endif
      aw_cnt = 0; beat = 0; done = 0; bv = v.b_early;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         req_addr = $urandom; req_len = 8'($urandom); req_strb = STRB_W'($urandom);
         req_data = {$urandom, $urandom, $urandom, $urandom};
         awready = (cyc >= v.aw_hold);
         case (v.wmode)
            0:       wready = 1'b1;
            1:       wready = (cyc % 2 == 0);
            default: wready = 1'($urandom_range(0, 1));
         endcase
         both = (aw_cnt == 1) && (beat == nbeats);
         if (!bv && both && $urandom_range(0, 1) == 1) bv = 1'b1;
         bvalid = bv;
         #1;
         chk("req_ready_busy", req_ready, 0);
         chk("awvalid", awvalid, aw_cnt == 0);
         chk("wvalid", wvalid, beat < nbeats);
         chk("bready", bready, both);
         chk("wr_done", wr_done, both && bv);
         if (awvalid) begin
            chk("awaddr", awaddr, v.addr);
            chk("awlen", awlen, v.exp_awlen);
            chk("awsize", awsize, v.size);
            chk("aw_const", {awid, awburst, awlock, awcache, awprot},
                {4'(AXI_ID), 2'b01, 2'b00, 4'b0000, 3'b000});
         end
         if (wvalid) begin
            exp_d = (beat < MAX_BEATS) ? v.data[beat*DATA_W +: DATA_W] : '0;
            chk("wdata", wdata, exp_d);
            chk("wlast", wlast, beat == nbeats - 1);
            chk("wstrb", wstrb, v.strb);
            chk("wid", wid, 4'(AXI_ID));
         end
`ifdef AXI_WR_RESP_EN
         chk("wr_err_cleared", wr_err, 0);
`endif
         if (awvalid && awready) aw_cnt++;
         if (wvalid && wready) beat++;
         if (bready && bvalid) done = 1'b1;
      end
      chk("txn_completed", done, 1);
      chk("beats_sent", beat, nbeats);
      exp_err = v.bresp[1];
      // Response still presented after the handshake must not pulse again.
      @(posedge clk); #1;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
      #1;
      chk("wr_done_single", wr_done, 0);
      chk("bready_after", bready, 0);
      chk("req_ready_after", req_ready, 1);
      chk("valids_after", {awvalid, wvalid}, 2'b00);
`ifdef AXI_WR_RESP_EN
      chk("wr_err_hold", wr_err, exp_err);
`endif
      @(posedge clk); #1;
      bvalid = 1'b0;
   endtask

   vec_t tbl[7];
   vec_t rv;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      idle_inputs();
      req_addr = '0; req_size = '0; req_len = '0; req_strb = '0; req_data = '0;

      tbl[0] = mk(32'h1000_0040, 8'd0, 4'hF, {96'h0, 32'hDEAD_BEEF}, 0, 0, 0, 2'b00, 8'd0);
      tbl[1] = mk(32'h2000_0000, 8'd3, 4'hF,
                  {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 0, 1, 0, 2'b00, 8'd3);
      tbl[2] = mk(32'h3000_0100, 8'd3, 4'hC,
                  {32'hA4A4_A4A4, 32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1}, 6, 0, 0, 2'b00, 8'd3);
      tbl[3] = mk(32'h4000_0200, 8'd2, 4'h3,
                  {32'h0, 32'hC3C3_C3C3, 32'hC2C2_C2C2, 32'hC1C1_C1C1}, 2, 1, 1, 2'b00, 8'd2);
      tbl[4] = mk(32'h5000_0000, 8'd9, 4'hF,
                  {32'hD4D4_D4D4, 32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1}, 0, 0, 0, 2'b10, 8'd3);
      tbl[5] = mk(32'h6000_0010, 8'd1, 4'h5,
                  {64'h0, 32'hE2E2_E2E2, 32'hE1E1_E1E1}, 1, 0, 0, 2'b00, 8'd1);
      tbl[6] = mk(32'h7000_0000, 8'd255, 4'hF,
                  {32'hF4F4_F4F4, 32'hF3F3_F3F3, 32'hF2F2_F2F2, 32'hF1F1_F1F1}, 3, 2, 1, 2'b11, 8'd3);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_valids", {awvalid, wvalid, bready, wr_done}, 4'b0000);
`ifdef AXI_WR_RESP_EN
      chk("rst_wr_err", wr_err, 0);
`endif
      resetn = 1'b1;

      for (int i = 0; i < 7; i++) run_txn(tbl[i]);

      // Reset in the middle of a 4-beat burst, after two W beats.
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = 32'h8000_0000; req_size = 3'd2; req_len = 8'd3;
      req_strb = 4'hF; req_data = {32'h9494_9494, 32'h9393_9393, 32'h9292_9292, 32'h9191_9191};
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         req_valid = 1'b0; awready = 1'b0; wready = 1'b1;
         #1;
         chk("mid_wvalid", wvalid, 1);
         chk("mid_wdata", wdata, (k == 0) ? 32'h9191_9191 : 32'h9292_9292);
      end
      @(posedge clk); #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      chk("abort_valids", {awvalid, wvalid, bready, wr_done}, 4'b0000);
      chk("abort_req_ready", req_ready, 0);
      idle_inputs();
      resetn = 1'b1;
      exp_err = 1'b0;
`ifdef AXI_WR_RESP_EN
      chk("abort_wr_err", wr_err, 0);
`endif
      run_txn(mk(32'h8000_1000, 8'd3, 4'hF,
                 {32'hB4B4_B4B4, 32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1}, 0, 0, 0, 2'b00, 8'd3));

      for (int n = 0; n < 40; n++) begin
         rv.addr = $urandom;
         rv.len = 8'($urandom_range(0, 12));
         rv.size = 3'($urandom_range(0, 2));
         rv.strb = STRB_W'($urandom);
         rv.data = {$urandom, $urandom, $urandom, $urandom};
         rv.aw_hold = $urandom_range(0, 8);
         rv.wmode = 2;
         rv.b_early = 1'($urandom_range(0, 1));
         rv.bresp = 2'($urandom);
         rv.exp_awlen = (int'(rv.len) > MAX_BEATS - 1) ? 8'(MAX_BEATS - 1) : rv.len;
         run_txn(rv);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
